// File: rtl/alu_pkg.sv
// Shared ALU select codes, RV32I opcodes and decode helper types.
// Imported by the decode/operand stage and the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_SLT    = 4'd5;
  localparam logic [3:0] ALU_SLTU   = 4'd6;
  localparam logic [3:0] ALU_SLL    = 4'd7;
  localparam logic [3:0] ALU_SRL    = 4'd8;
  localparam logic [3:0] ALU_SRA    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_U,
    IMM_SHAMT,
    IMM_FOUR
  } imm_fmt_e;

  typedef enum logic [1:0] {
    A_RS1,
    A_PC,
    A_ZERO
  } a_src_e;

  // funct7[5] selects SUB only for register-register ops; SRA/SRAI both honour it
  function automatic logic [3:0] funct_sel(input logic [2:0] f3, input logic f7b5,
                                           input logic is_reg);
    logic [3:0] sel;
    sel = ALU_ADD;
    case (f3)
      3'b000:  sel = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  sel = ALU_SLL;
      3'b010:  sel = ALU_SLT;
      3'b011:  sel = ALU_SLTU;
      3'b100:  sel = ALU_XOR;
      3'b101:  sel = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  sel = ALU_OR;
      default: sel = ALU_AND;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      IMM_I:     imm = {{20{i[31]}}, i[31:20]};
      IMM_S:     imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_U:     imm = {i[31:12], 12'b0};
      IMM_SHAMT: imm = {27'b0, i[24:20]};
      IMM_FOUR:  imm = 32'd4;
      default:   imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Upstream/downstream bundle of the decode/operand stage.
// master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            exm_wen;
  logic [4:0]      exm_rd;
  logic [XLEN-1:0] exm_val;
  logic            wb_wen;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_val;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] a_val;
  logic [XLEN-1:0] b_val;
  logic [3:0]      alu_sel;
  logic [4:0]      rd;
  logic            rd_wen;
  logic [XLEN-1:0] store_data;
  logic            illegal;

  modport master (
    output in_valid, inst, pc, rs1_data, rs2_data,
           exm_wen, exm_rd, exm_val, wb_wen, wb_rd, wb_val,
           flush, out_ready,
    input  in_ready, out_valid, a_val, b_val, alu_sel, rd, rd_wen, store_data, illegal
  );

  modport slave (
    input  in_valid, inst, pc, rs1_data, rs2_data,
           exm_wen, exm_rd, exm_val, wb_wen, wb_rd, wb_val,
           flush, out_ready,
    output in_ready, out_valid, a_val, b_val, alu_sel, rd, rd_wen, store_data, illegal
  );
endinterface

// File: rtl/alu_decode.sv
// RV32I decoder: ALU select, operand sources, immediate, rd_wen, illegal.
// Latency: combinational. Backpressure: none, pure function of inst_i.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [3:0]  alu_sel_o,
  output a_src_e      a_src_o,
  output logic        b_imm_o,
  output logic [31:0] imm_o,
  output logic        rd_wen_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic       wen;
  imm_fmt_e   fmt;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7b5   = inst_i[30];

  always_comb begin
    alu_sel_o = ALU_ADD;
    a_src_o   = A_RS1;
    b_imm_o   = 1'b0;
    fmt       = IMM_NONE;
    wen       = 1'b0;
    illegal_o = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_sel_o = funct_sel(f3, f7b5, 1'b1);
        wen       = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_sel_o = funct_sel(f3, f7b5, 1'b0);
        b_imm_o   = 1'b1;
        fmt       = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
        wen       = 1'b1;
      end
      OPC_LOAD: begin
        b_imm_o = 1'b1;
        fmt     = IMM_I;
        wen     = 1'b1;
      end
      OPC_STORE: begin
        b_imm_o = 1'b1;
        fmt     = IMM_S;
      end
      OPC_LUI: begin
        alu_sel_o = ALU_PASS_B;
        a_src_o   = A_ZERO;
        b_imm_o   = 1'b1;
        fmt       = IMM_U;
        wen       = 1'b1;
      end
      OPC_AUIPC: begin
        a_src_o = A_PC;
        b_imm_o = 1'b1;
        fmt     = IMM_U;
        wen     = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // link value pc+4 is produced by the ALU
        a_src_o = A_PC;
        b_imm_o = 1'b1;
        fmt     = IMM_FOUR;
        wen     = 1'b1;
      end
      OPC_BRANCH: begin
        alu_sel_o = ALU_SUB;
      end
      default: begin
        illegal_o = 1'b1;
        a_src_o   = A_ZERO;
        b_imm_o   = 1'b1;
        fmt       = IMM_NONE;
      end
    endcase
  end

  assign imm_o    = imm_gen(inst_i, fmt);
  assign rd_wen_o = wen && (inst_i[11:7] != 5'd0);

endmodule

// File: rtl/id_ex_stage.sv
// Decode/operand stage feeding the ALU; forwarding muxes built only with ID_EX_FWD_EN.
// Latency: 1 cycle capture->out_valid, 1 op/cycle. Backpressure: in_ready = !out_valid || out_ready,
// outputs hold bit-stable while out_valid && !out_ready.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic          clk_i,
  input logic          rst_n_i,
  id_ex_stage_if.slave bus
);

  logic [3:0]      dec_sel;
  a_src_e          dec_a_src;
  logic            dec_b_imm;
  logic [31:0]     dec_imm;
  logic            dec_rd_wen;
  logic            dec_illegal;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_v;
  logic [XLEN-1:0] rs2_v;
  logic [XLEN-1:0] a_nx;
  logic [XLEN-1:0] b_nx;
  logic            capture;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] store_q, store_d;
  logic [3:0]      sel_q, sel_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_wen_q, rd_wen_d;
  logic            illegal_q, illegal_d;

  alu_decode u_dec (
    .inst_i   (bus.inst),
    .alu_sel_o(dec_sel),
    .a_src_o  (dec_a_src),
    .b_imm_o  (dec_b_imm),
    .imm_o    (dec_imm),
    .rd_wen_o (dec_rd_wen),
    .illegal_o(dec_illegal)
  );

  assign rs1 = bus.inst[19:15];
  assign rs2 = bus.inst[24:20];

`ifdef ID_EX_FWD_EN
  // EX/MEM is the younger result, so it wins over MEM/WB; x0 never forwards
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0] rs, input logic [XLEN-1:0] rf,
    input logic ew, input logic [4:0] er, input logic [XLEN-1:0] ev,
    input logic ww, input logic [4:0] wr, input logic [XLEN-1:0] wv
  );
    if (ew && er == rs && rs != 5'd0) return ev;
    else if (ww && wr == rs && rs != 5'd0) return wv;
    else return rf;
  endfunction

  assign rs1_v = fwd(rs1, bus.rs1_data, bus.exm_wen, bus.exm_rd, bus.exm_val,
                     bus.wb_wen, bus.wb_rd, bus.wb_val);
  assign rs2_v = fwd(rs2, bus.rs2_data, bus.exm_wen, bus.exm_rd, bus.exm_val,
                     bus.wb_wen, bus.wb_rd, bus.wb_val);
`else
  assign rs1_v = bus.rs1_data;
  assign rs2_v = bus.rs2_data;
`endif

  always_comb begin
    a_nx = '0;
    case (dec_a_src)
      A_RS1:   a_nx = rs1_v;
      A_PC:    a_nx = bus.pc;
      default: a_nx = '0;
    endcase
  end

  assign b_nx = dec_b_imm ? XLEN'($signed(dec_imm)) : rs2_v;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    store_d     = store_q;
    sel_d       = sel_q;
    rd_d        = rd_q;
    rd_wen_d    = rd_wen_q;
    illegal_d   = illegal_q;
    if (capture) begin
      out_valid_d = 1'b1;
      a_d         = a_nx;
      b_d         = b_nx;
      store_d     = rs2_v;
      sel_d       = dec_sel;
      rd_d        = bus.inst[11:7];
      rd_wen_d    = dec_rd_wen;
      illegal_d   = dec_illegal;
    end else if (bus.flush || bus.out_ready) begin
      // payload is left in place; only the valid bit is dropped
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      store_q     <= '0;
      sel_q       <= ALU_ADD;
      rd_q        <= '0;
      rd_wen_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      store_q     <= store_d;
      sel_q       <= sel_d;
      rd_q        <= rd_d;
      rd_wen_q    <= rd_wen_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.a_val      = a_q;
  assign bus.b_val      = b_q;
  assign bus.store_data = store_q;
  assign bus.alu_sel    = sel_q;
  assign bus.rd         = rd_q;
  assign bus.rd_wen     = rd_wen_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with a queue scoreboard popped on every consumed slot.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        illegal;
    logic        rd_wen;
    logic [4:0]  rd;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
  } exp_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        ew;
    logic [4:0]  er;
    logic [31:0] ev;
    logic        ww;
    logic [4:0]  wr;
    logic [31:0] wv;
  } stim_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t q[$];
  exp_t mon_e;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic wen, input logic [31:0] st,
                              input logic ill);
    return {ill, wen, rd, sel, a, b, st};
  endfunction

  function automatic stim_t sv(input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic ew, input logic [4:0] er, input logic [31:0] ev,
                               input logic ww, input logic [4:0] wr, input logic [31:0] wv);
    return {inst, pc, r1, r2, ew, er, ev, ww, wr, wv};
  endfunction

  function automatic exp_t cur();
    return {bus.illegal, bus.rd_wen, bus.rd, bus.alu_sel, bus.a_val, bus.b_val, bus.store_data};
  endfunction

  task automatic chk(input string name, input exp_t act, input exp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ill=%0b wen=%0b rd=%0d sel=%0d a=%h b=%h st=%h, want ill=%0b wen=%0b rd=%0d sel=%0d a=%h b=%h st=%h",
               name, act.illegal, act.rd_wen, act.rd, act.sel, act.a, act.b, act.st,
               exp.illegal, exp.rd_wen, exp.rd, exp.sel, exp.a, exp.b, exp.st);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.inst     = s.inst;
    bus.pc       = s.pc;
    bus.rs1_data = s.r1;
    bus.rs2_data = s.r2;
    bus.exm_wen  = s.ew;
    bus.exm_rd   = s.er;
    bus.exm_val  = s.ev;
    bus.wb_wen   = s.ww;
    bus.wb_rd    = s.wr;
    bus.wb_val   = s.wv;
  endtask

  // Called just after a rising edge; returns just after the capture edge.
  task automatic send(input string name, input stim_t s, input exp_t e);
    bit got;
    got = 1'b0;
    drive(s);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        got = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: in_ready never rose within 20 cycles", name);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_slot: out_valid=1 with empty scoreboard, rd=%0d", bus.rd);
      end else begin
        mon_e = q.pop_front();
        chk("slot", cur(), mon_e);
      end
    end
  end

  stim_t s_or, s_beq;
  exp_t  e_or, e_beq;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(sv(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0));
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    #3;
    chk1("reset_out_valid", bus.out_valid, 1'b0);
    chk1("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_payload", cur(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADDI x5,x0,-100
    send("addi", sv(32'hF9C00293, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd0, 32'h0, 32'hFFFFFF9C, 5'd5, 1'b1, 32'h0, 1'b0));
    // SUB x3,x1,x2
    send("sub", sv(32'h402081B3, 32'h0, 32'd1, 32'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd1, 32'd1, 32'd2, 5'd3, 1'b1, 32'd2, 1'b0));
    // SRAI x4,x1,1: EX/MEM hit beats MEM/WB hit; rs2 field is also x1
    send("srai_fwd", sv(32'h4010D213, 32'h0, 32'hFFFFFFF8, 32'h11, 1'b1, 5'd1, 32'hFFFFFFF0,
                        1'b1, 5'd1, 32'd7),
         mk(4'd9, FWD ? 32'hFFFFFFF0 : 32'hFFFFFFF8, 32'd1, 5'd4, 1'b1,
            FWD ? 32'hFFFFFFF0 : 32'h11, 1'b0));
    // ADD x6,x0,x2 with a bogus EX/MEM write to x0
    send("add_x0", sv(32'h00200333, 32'h0, 32'h0, 32'd9, 1'b1, 5'd0, 32'd55, 1'b0, 5'd0, 32'h0),
         mk(4'd0, 32'h0, 32'd9, 5'd6, 1'b1, 32'd9, 1'b0));
    // ADD x11,x1,x2 with MEM/WB hit on x2 only
    send("add_wb", sv(32'h002085B3, 32'h0, 32'd1, 32'd2, 1'b1, 5'd3, 32'd99, 1'b1, 5'd2, 32'h77),
         mk(4'd0, 32'd1, FWD ? 32'h77 : 32'd2, 5'd11, 1'b1, FWD ? 32'h77 : 32'd2, 1'b0));
    // LUI x7,0x12345 (a is zero)
    send("lui", sv(32'h123453B7, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd10, 32'h0, 32'h12345000, 5'd7, 1'b1, 32'h0, 1'b0));
    // AUIPC x8,0x1 at pc 0x100
    send("auipc", sv(32'h00001417, 32'h100, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd0, 32'h100, 32'h1000, 5'd8, 1'b1, 32'h0, 1'b0));
    // JAL x1 at pc 0x200
    send("jal", sv(32'h000000EF, 32'h200, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd0, 32'h200, 32'd4, 5'd1, 1'b1, 32'h0, 1'b0));
    // SW x5,8(x2)
    send("sw", sv(32'h00512423, 32'h0, 32'h1000, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd0, 32'h1000, 32'd8, 5'd8, 1'b0, 32'hDEAD, 1'b0));
    // ADDI x0,x0,1: rd=0 suppresses the write
    send("addi_rd0", sv(32'h00100013, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd0, 32'h0, 32'd1, 5'd0, 1'b0, 32'h0, 1'b0));

    // Stall: OR x10,x1,x2 sits while BEQ waits upstream
    s_or  = sv(32'h0020E533, 32'h0, 32'hF0, 32'h0F, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    e_or  = mk(4'd3, 32'hF0, 32'h0F, 5'd10, 1'b1, 32'h0F, 1'b0);
    s_beq = sv(32'h00208063, 32'h0, 32'd5, 32'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    e_beq = mk(4'd1, 32'd5, 32'd5, 5'd0, 1'b0, 32'd5, 1'b0);
    send("or", s_or, e_or);
    bus.out_ready = 1'b0;
    drive(s_beq);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("stall_in_ready", bus.in_ready, 1'b0);
      chk1("stall_valid", bus.out_valid, 1'b1);
      chk("stall_hold", cur(), e_or);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send("beq", s_beq, e_beq);
    chk1("no_bubble", bus.out_valid, 1'b1);

    // Flush during a capture: nothing enters the slot
    drive(sv(32'h00A00093, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0));
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk1("flush_kill", bus.out_valid, 1'b0);

    // Opcode 1111111 with rd field 7
    send("illegal", sv(32'h000003FF, 32'h40, 32'h33, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd0, 32'h0, 32'h0, 5'd7, 1'b0, 32'h0, 1'b1));

    // Async reset while a slot is stalled
    send("lui_rst", sv(32'h123453B7, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd10, 32'h0, 32'h12345000, 5'd7, 1'b1, 32'h0, 1'b0));
    bus.out_ready = 1'b0;
    chk1("pre_reset_valid", bus.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_valid", bus.out_valid, 1'b0);
    chk1("async_rst_in_ready", bus.in_ready, 1'b1);
    chk("async_rst_payload", cur(), '0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send("auipc_post", sv(32'h00001417, 32'h8, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0),
         mk(4'd0, 32'h8, 32'h1000, 5'd8, 1'b1, 32'h0, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    chk1("drain_empty", q.size() == 0, 1'b1);
    chk1("drain_idle", bus.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
